// File: rtl/carregador_de_programa_if.sv
// Byte-stream receive handshake plus instruction-memory write port of the boot loader.
// master = serial receiver / memory side, slave = loader.
interface carregador_de_programa_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_we, mem_addr, mem_datain
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_we, mem_addr, mem_datain
    );
endinterface

// File: rtl/carregador_de_programa.sv
// Boot-time program loader: assembles a length-prefixed big-endian byte stream into
// 32-bit words, writes them to instruction memory and holds the CPU until the image is complete.
module carregador_de_programa #(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    carregador_de_programa_if.slave bus,
    output logic                    cpu_hold,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [ADDR_W:0]         words_loaded
);
    localparam int unsigned WL      = ADDR_W + 1;
    localparam logic [16:0] MAX_LEN = 17'(2 ** ADDR_W);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t          state;
    logic [7:0]      len_hi;
    logic [ADDR_W:0] len;
    logic [23:0]     shreg;
    logic [1:0]      cnt;
    logic [31:0]     tmo;

    logic            xfer;
    logic            rx_phase;
    logic [15:0]     len_full;
    logic            len_bad;
    logic            tmo_hit;
    logic [ADDR_W:0] wl_next;

    assign xfer     = bus.rx_valid & bus.rx_ready;
    assign rx_phase = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
    assign len_full = {len_hi, bus.rx_data};
    assign len_bad  = (len_full == '0) || ({1'b0, len_full} > MAX_LEN);
    assign tmo_hit  = (TIMEOUT_CYC != 0) && (tmo == TIMEOUT_CYC - 1);
    assign wl_next  = words_loaded + WL'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cpu_hold       <= 1'b1;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            words_loaded   <= '0;
            bus.rx_ready   <= 1'b0;
            bus.mem_we     <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_datain <= '0;
            len_hi         <= '0;
            len            <= '0;
            shreg          <= '0;
            cnt            <= '0;
            tmo            <= '0;
        end else begin
            // Idle-cycle watchdog shared by every byte-receiving state; a partial word is dropped.
            if (rx_phase) begin
                if (xfer) begin
                    tmo <= '0;
                end else if (tmo_hit) begin
                    state        <= ERR;
                    error        <= 1'b1;
                    busy         <= 1'b0;
                    bus.rx_ready <= 1'b0;
                end else if (TIMEOUT_CYC != 0) begin
                    tmo <= tmo + 32'd1;
                end
            end

            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state        <= LEN_HI;
                        bus.rx_ready <= 1'b1;
                        busy         <= 1'b1;
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        tmo          <= '0;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len_hi <= bus.rx_data;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        if (len_bad) begin
                            state        <= ERR;
                            error        <= 1'b1;
                            busy         <= 1'b0;
                            bus.rx_ready <= 1'b0;
                        end else begin
                            len   <= WL'(len_full);
                            cnt   <= '0;
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        shreg <= {shreg[15:0], bus.rx_data};
                        cnt   <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            state          <= WRITE;
                            bus.rx_ready   <= 1'b0;
                            bus.mem_we     <= 1'b1;
                            bus.mem_addr   <= 32'(words_loaded[ADDR_W-1:0]);
                            bus.mem_datain <= {shreg, bus.rx_data};
                        end
                    end
                end
                WRITE: begin
                    bus.mem_we   <= 1'b0;
                    words_loaded <= wl_next;
                    if (wl_next == len) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        state        <= DATA;
                        bus.rx_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_carregador_de_programa.sv
// Scoreboard bench for the program loader: stimulus queues expected memory writes,
// a negedge monitor pops and compares each mem_we pulse.
module tb_carregador_de_programa;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [12:0] words_loaded;

    carregador_de_programa_if bus ();

    carregador_de_programa #(
        .ADDR_W      (12),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    logic [31:0] last_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write pulse must match the head of the expectation queue.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_t e;
            wr_cnt++;
            last_addr = bus.mem_addr;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         bus.mem_addr, bus.mem_datain);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", bus.mem_addr, e.addr);
                check("wr_data", bus.mem_datain, e.data);
            end
        end
    end

    function automatic logic [31:0] pat(input int unsigned i);
        logic [31:0] v;
        v = {4'hA, i[11:0], ~i[15:0]};
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        bit   ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            bus.rx_data  = b;
            bus.rx_valid = 1'b1;
            rdy = bus.rx_ready;
            @(posedge clk);
            if (rdy) ok = 1'b1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL byte_accept: byte %h not accepted within 64 cycles", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8]);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
        end
    endtask

    task automatic pulse_start;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            if (done || error) seen = 1'b1;
        end
        if (!seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL end_wait: got no done/error expected one within %0d cycles", budget);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1);
    end

    initial begin
        int          wr0;
        logic [7:0]  gap_bytes[10];

        rst_n = 1'b0;
        start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);

        // Two-word image.
        wr0 = wr_cnt;
        exp_q.push_back('{addr: 32'h0, data: 32'hDEADBEEF});
        exp_q.push_back('{addr: 32'h1, data: 32'h01234567});
        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        check("start_rx_ready", 32'(bus.rx_ready), 32'd1);
        send_byte(8'h00);
        send_byte(8'h02);
        send_word(32'hDEADBEEF);
        send_word(32'h01234567);
        wait_end(50);
        check("l2_done", 32'(done), 32'd1);
        check("l2_error", 32'(error), 32'd0);
        check("l2_cpu_hold", 32'(cpu_hold), 32'd0);
        check("l2_busy", 32'(busy), 32'd0);
        check("l2_words", 32'(words_loaded), 32'd2);
        check("l2_wr_count", 32'(wr_cnt - wr0), 32'd2);

        // Illegal lengths, then timeout waiting for LEN_HI.
        wr0 = wr_cnt;
        pulse_start();
        check("restart_done_clr", 32'(done), 32'd0);
        check("restart_cpu_hold", 32'(cpu_hold), 32'd1);
        send_byte(8'h00);
        send_byte(8'h00);
        idle(1);
        check("len0_error", 32'(error), 32'd1);
        check("len0_done", 32'(done), 32'd0);
        check("len0_cpu_hold", 32'(cpu_hold), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        pulse_start();
        check("err_clr", 32'(error), 32'd0);
        send_byte(8'h10);
        send_byte(8'h01);
        idle(1);
        check("len1001_error", 32'(error), 32'd1);
        pulse_start();
        check("err_clr2", 32'(error), 32'd0);
        idle(20);
        check("tmo_len_hi_error", 32'(error), 32'd1);
        check("len_err_no_wr", 32'(wr_cnt - wr0), 32'd0);

        // Stall mid-word: error exactly 16 cycles after the last accepted byte.
        wr0 = wr_cnt;
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'hAA);
        send_byte(8'hBB);
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            bus.rx_valid = 1'b0;
            if (i == 15) check("tmo_before", 32'(error), 32'd0);
            if (i == 16) check("tmo_at_16", 32'(error), 32'd1);
        end
        check("tmo_no_wr", 32'(wr_cnt - wr0), 32'd0);
        check("tmo_cpu_hold", 32'(cpu_hold), 32'd1);

        // Gaps shorter than the timeout must not abort the load.
        gap_bytes = '{8'h00, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'h13, 8'h57, 8'h9B, 8'hDF};
        exp_q.push_back('{addr: 32'h0, data: 32'hCAFEF00D});
        exp_q.push_back('{addr: 32'h1, data: 32'h13579BDF});
        pulse_start();
        foreach (gap_bytes[j]) begin
            send_byte(gap_bytes[j]);
            idle(int'($urandom_range(0, 14)));
        end
        wait_end(50);
        check("gap_done", 32'(done), 32'd1);
        check("gap_error", 32'(error), 32'd0);
        check("gap_words", 32'(words_loaded), 32'd2);

        // Reset after the first write of a three-word load.
        wr0 = wr_cnt;
        exp_q.push_back('{addr: 32'h0, data: 32'h11111111});
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h03);
        send_word(32'h11111111);
        idle(2);
        check("pre_rst_words", 32'(words_loaded), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_cpu_hold", 32'(cpu_hold), 32'd1);
        check("arst_rx_ready", 32'(bus.rx_ready), 32'd0);
        check("arst_mem_we", 32'(bus.mem_we), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_words", 32'(words_loaded), 32'd0);
        check("arst_addr", bus.mem_addr, 32'd0);
        check("arst_data", bus.mem_datain, 32'd0);
        idle(3);
        rst_n = 1'b1;
        exp_q.push_back('{addr: 32'h0, data: 32'hA1A2A3A4});
        exp_q.push_back('{addr: 32'h1, data: 32'hB1B2B3B4});
        exp_q.push_back('{addr: 32'h2, data: 32'hC1C2C3C4});
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h03);
        send_word(32'hA1A2A3A4);
        send_word(32'hB1B2B3B4);
        send_word(32'hC1C2C3C4);
        wait_end(50);
        check("post_rst_done", 32'(done), 32'd1);
        check("post_rst_words", 32'(words_loaded), 32'd3);
        check("post_rst_wr_count", 32'(wr_cnt - wr0), 32'd4);

        // Full 4096-word image with an ignored start mid-load.
        wr0 = wr_cnt;
        for (int unsigned i = 0; i < 4096; i++)
            exp_q.push_back('{addr: 32'(i), data: pat(i)});
        pulse_start();
        send_byte(8'h10);
        send_byte(8'h00);
        for (int unsigned i = 0; i < 4096; i++) begin
            send_word(pat(i));
            if (i == 1999) begin
                pulse_start();
                check("mid_start_words", 32'(words_loaded), 32'd2000);
                check("mid_start_busy", 32'(busy), 32'd1);
                check("mid_start_done", 32'(done), 32'd0);
            end
        end
        wait_end(100);
        check("full_done", 32'(done), 32'd1);
        check("full_error", 32'(error), 32'd0);
        check("full_words", 32'(words_loaded), 32'd4096);
        check("full_last_addr", last_addr, 32'h0FFF);
        check("full_wr_count", 32'(wr_cnt - wr0), 32'd4096);
        idle(2);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
